// File: rtl/datapath_pkg.sv
// Shared datapath definitions: default data width and result-demux select encodings.
package datapath_pkg;

    localparam int unsigned DP_WIDTH = 16;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage : datapath_pkg

// File: rtl/result_demux_fifo.sv
// Synchronous FIFO with registered storage and combinational head read.
// Pointers wrap naturally; occupancy is one bit wider than the pointers.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 2
) (
    input  logic             CLOCK,
    input  logic             CLEAR_N,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    // Push is refused when full even if a pop happens in the same cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    assign full  = (occ == OCC_W'(DEPTH));
    assign empty = (occ == '0);
    assign rdata = mem[rd_ptr];

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/result_demux.sv
// 1-to-2 result demultiplexer: steers each accepted word into one of two
// independent output FIFOs and counts the words routed to each.
module result_demux
    import datapath_pkg::*;
#(
    parameter int unsigned WIDTH = DP_WIDTH,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 8
) (
    input  logic             CLOCK,
    input  logic             CLEAR_N,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic accept;
    logic push0;
    logic push1;

    always_comb begin
        in_ready = 1'b0;
        if (CLEAR_N) begin
            in_ready = (in_sel == SEL_OUT1) ? ~full1 : ~full0;
        end
    end

    assign accept = in_valid & in_ready;
    assign push0  = accept & (in_sel == SEL_OUT0);
    assign push1  = accept & (in_sel == SEL_OUT1);

    assign out0_valid = ~empty0;
    assign out1_valid = ~empty1;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .CLOCK   (CLOCK),
        .CLEAR_N (CLEAR_N),
        .push    (push0),
        .pop     (out0_ready),
        .wdata   (in_data),
        .rdata   (out0_data),
        .full    (full0),
        .empty   (empty0)
    );

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .CLOCK   (CLOCK),
        .CLEAR_N (CLEAR_N),
        .push    (push1),
        .pop     (out1_ready),
        .wdata   (in_data),
        .rdata   (out1_data),
        .full    (full1),
        .empty   (empty1)
    );

    always_ff @(posedge CLOCK) begin
        if (!CLEAR_N) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end
            if (push1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end
        end
    end

endmodule : result_demux

// File: tb/tb_result_demux.sv
// Scoreboard bench for result_demux: the driver queues expected words on
// acceptance, a negedge monitor pops and compares on every output handshake.
module tb_result_demux;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_sel;
    logic [15:0] in_data;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_data;
    logic [7:0]  cnt0;
    logic [7:0]  cnt1;

    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [7:0]  m_cnt0;
    logic [7:0]  m_cnt1;
    int unsigned total = 0;
    int unsigned bad = 0;

    always #5 clk = ~clk;

    result_demux #(
        .WIDTH (16),
        .DEPTH (2),
        .CNT_W (8)
    ) dut (
        .CLOCK      (clk),
        .CLEAR_N    (clear_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sel     (in_sel),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output handshakes are stable at the negedge and complete at the next posedge.
    always @(negedge clk) begin
        if (clear_n === 1'b1) begin
            if (out0_valid === 1'b1 && out0_ready === 1'b1) begin
                if (q0.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out0_unexpected: got %0h expected none at %0t", out0_data, $time);
                end else begin
                    chk("out0_data", {16'h0, out0_data}, {16'h0, q0.pop_front()});
                end
            end
            if (out1_valid === 1'b1 && out1_ready === 1'b1) begin
                if (q1.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out1_unexpected: got %0h expected none at %0t", out1_data, $time);
                end else begin
                    chk("out1_data", {16'h0, out1_data}, {16'h0, q1.pop_front()});
                end
            end
        end
    end

    task automatic send(input logic sel, input logic [15:0] d, input bit chk_lat);
        int unsigned n = 0;
        bit acc = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                acc = 1;
                if (sel) begin
                    q1.push_back(d);
                    m_cnt1++;
                end else begin
                    q0.push_back(d);
                    m_cnt0++;
                end
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles expected accept of %0h", d);
        end else if (chk_lat) begin
            chk("latency_valid", {31'h0, sel ? out1_valid : out0_valid}, 32'd1);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        clear_n    = 1'b0;
        in_valid   = 1'b1;
        in_sel     = 1'b0;
        in_data    = 16'h5;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        m_cnt0     = '0;
        m_cnt1     = '0;

        // 1: reset held two cycles with a word offered
        repeat (2) begin
            @(negedge clk);
            chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
            chk("rst_out0_valid", {31'h0, out0_valid}, 32'd0);
            chk("rst_out1_valid", {31'h0, out1_valid}, 32'd0);
            chk("rst_cnt0", {24'h0, cnt0}, 32'd0);
            chk("rst_cnt1", {24'h0, cnt1}, 32'd0);
        end
        in_valid = 1'b0;
        clear_n  = 1'b1;
        idle(1);
        chk("post_rst_cnt0", {24'h0, cnt0}, 32'd0);
        chk("post_rst_out0_valid", {31'h0, out0_valid}, 32'd0);

        // 2: routing
        send(1'b0, 16'd20, 1);
        send(1'b1, 16'd60, 1);
        send(1'b0, 16'd50, 1);
        idle(3);
        chk("route_cnt0", {24'h0, cnt0}, 32'd2);
        chk("route_cnt1", {24'h0, cnt1}, 32'd1);
        chk("route_q0_drained", q0.size(), 32'd0);
        chk("route_q1_drained", q1.size(), 32'd0);

        // 3: full / backpressure
        out0_ready = 1'b0;
        send(1'b0, 16'd40, 1);
        send(1'b0, 16'd80, 0);
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'd90;
        #1;
        chk("full_in_ready_sel0", {31'h0, in_ready}, 32'd0);
        in_sel = 1'b1;
        #1;
        chk("full_in_ready_sel1", {31'h0, in_ready}, 32'd1);
        in_valid   = 1'b0;
        in_sel     = 1'b0;
        out0_ready = 1'b1;
        #1;
        chk("full_no_bypass", {31'h0, in_ready}, 32'd0);
        idle(3);
        chk("full_q0_drained", q0.size(), 32'd0);
        chk("full_out0_empty", {31'h0, out0_valid}, 32'd0);

        // 4: simultaneous push and pop
        out0_ready = 1'b0;
        send(1'b0, 16'd70, 1);
        out0_ready = 1'b1;
        send(1'b0, 16'd100, 0);
        chk("pp_out0_valid", {31'h0, out0_valid}, 32'd1);
        chk("pp_out0_data", {16'h0, out0_data}, 32'd100);
        idle(2);
        chk("pp_out0_empty", {31'h0, out0_valid}, 32'd0);
        chk("pp_q0_drained", q0.size(), 32'd0);

        // 5: reset during operation
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        send(1'b0, 16'd11, 0);
        send(1'b1, 16'd22, 0);
        send(1'b0, 16'd33, 0);
        chk("mid_out0_valid", {31'h0, out0_valid}, 32'd1);
        chk("mid_out1_valid", {31'h0, out1_valid}, 32'd1);
        clear_n = 1'b0;
        q0.delete();
        q1.delete();
        m_cnt0 = '0;
        m_cnt1 = '0;
        idle(1);
        clear_n = 1'b1;
        chk("mid_rst_out0_valid", {31'h0, out0_valid}, 32'd0);
        chk("mid_rst_out1_valid", {31'h0, out1_valid}, 32'd0);
        chk("mid_rst_cnt0", {24'h0, cnt0}, 32'd0);
        chk("mid_rst_cnt1", {24'h0, cnt1}, 32'd0);
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        idle(4);
        chk("mid_rst_stale0", {31'h0, out0_valid}, 32'd0);
        chk("mid_rst_stale1", {31'h0, out1_valid}, 32'd0);

        // 6: counter wrap on channel 1
        for (int i = 0; i < 256; i++) begin
            send(1'b1, 16'h1000 + 16'(i), 0);
            if (i == 254) begin
                chk("wrap_cnt1_255", {24'h0, cnt1}, 32'd255);
            end
        end
        chk("wrap_cnt1", {24'h0, cnt1}, 32'd0);
        chk("wrap_cnt1_model", {24'h0, cnt1}, {24'h0, m_cnt1});
        chk("wrap_cnt0", {24'h0, cnt0}, 32'd0);
        idle(3);
        chk("wrap_q1_drained", q1.size(), 32'd0);
        chk("end_q0_drained", q0.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_result_demux
